// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard unit: forwarding-mux encodings,
// default register-file size and the multi-cycle down-counter width.
package hazard_pkg;

    // Forwarding mux select seen by the EX-stage operand muxes
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    localparam int NREG_DEFAULT = 16;
    localparam int CNT_W        = 4;

    // MEM is the youngest producer, so it takes priority over WB
    function automatic fwd_sel_e fwd_select(input logic match_m, input logic match_w);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (match_m) begin
            sel = FWD_M;
        end else if (match_w) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mul_tracker.sv
// Multi-cycle unit tracker: latency down-counter, per-register scoreboard
// and the latched destination of the op currently in flight.
// MUL_LAT must lie in 2..15 so that MUL_LAT-1 fits the 4-bit counter.
module mul_tracker
    import hazard_pkg::*;
#(
    parameter int NREG    = NREG_DEFAULT,
    parameter int MUL_LAT = 3,
    localparam int RW     = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_i,
    input  logic [RW-1:0]   issue_wa_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [RW-1:0]   done_wa_o,
    output logic [NREG-1:0] sb_o
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MUL_LAT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREG-1:0]  sb_q, sb_d;
    logic [RW-1:0]    wa_q, wa_d;
    logic             last_cycle;

    // Next-state for counter, scoreboard and latched address; a new issue
    // is applied after the retiring clear so a same-register reissue keeps its bit set
    always_comb begin
        cnt_d      = cnt_q;
        sb_d       = sb_q;
        wa_d       = wa_q;
        last_cycle = (cnt_q == CNT_W'(1));
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (last_cycle) begin
            sb_d[wa_q] = 1'b0;
        end
        if (issue_i) begin
            cnt_d            = LAT_LOAD;
            sb_d[issue_wa_i] = 1'b1;
            wa_d             = issue_wa_i;
        end
    end

    // Status outputs are forced quiet while reset is held so an abandoned op never signals completion
    always_comb begin
        busy_o    = (cnt_q != '0) && !reset;
        done_o    = last_cycle && !reset;
        done_wa_o = wa_q;
        sb_o      = sb_q;
    end

    // Tracker state registers with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            sb_q  <= '0;
            wa_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sb_q  <= sb_d;
            wa_q  <= wa_d;
        end
    end

endmodule

// File: rtl/hazard_unit_sb.sv
// Pipeline hazard unit with a scoreboard for one multi-cycle execution unit.
// Handles operand forwarding, load-use and scoreboard RAW stalls, the
// structural stall on a busy multi-cycle unit, and branch/PC-write flushes.
// Optional build macro HAZARD_UNIT_PERF_EN adds saturating StallCnt/FlushCnt.
module hazard_unit_sb
    import hazard_pkg::*;
#(
    parameter int NREG    = NREG_DEFAULT,
    parameter int MUL_LAT = 3,
    localparam int RW     = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [RW-1:0] RA1D,
    input  logic [RW-1:0] RA2D,
    input  logic [RW-1:0] RA1E,
    input  logic [RW-1:0] RA2E,
    input  logic [RW-1:0] WA3E,
    input  logic [RW-1:0] WA3M,
    input  logic [RW-1:0] WA3W,
    input  logic          RegWriteM,
    input  logic          RegWriteW,
    input  logic          MemtoRegE,
    input  logic          MulStartE,
    input  logic [RW-1:0] MulWAE,
    input  logic          PCSrcD,
    input  logic          PCSrcE,
    input  logic          PCSrcM,
    input  logic          PCSrcW,
    input  logic          BranchTakenE,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic          StallF,
    output logic          StallD,
    output logic          StallE,
    output logic          FlushD,
    output logic          FlushE,
    output logic          MulBusy,
    output logic          MulDoneW,
    output logic [RW-1:0] MulWAW
`ifdef HAZARD_UNIT_PERF_EN
    ,
    output logic [15:0]   StallCnt,
    output logic [15:0]   FlushCnt
`endif
);

    logic            mul_busy;
    logic            mul_done;
    logic [RW-1:0]   mul_done_wa;
    logic [NREG-1:0] sb;
    logic            issue_accept;
    logic            load_use;
    logic            sb_raw_a;
    logic            sb_raw_b;
    logic            sb_raw;
    logic            struct_hz;
    logic            pc_pending;
    logic            stall_f;
    logic            stall_d;
    logic            stall_e;
    logic            flush_d;
    logic            flush_e;

    mul_tracker #(
        .NREG    (NREG),
        .MUL_LAT (MUL_LAT)
    ) u_mul_tracker (
        .clk        (clk),
        .reset      (reset),
        .issue_i    (issue_accept),
        .issue_wa_i (MulWAE),
        .busy_o     (mul_busy),
        .done_o     (mul_done),
        .done_wa_o  (mul_done_wa),
        .sb_o       (sb)
    );

    // Per-operand forwarding select from the MEM and WB destinations
    always_comb begin
        ForwardAE = fwd_select(RegWriteM && (RA1E == WA3M), RegWriteW && (RA1E == WA3W));
        ForwardBE = fwd_select(RegWriteM && (RA2E == WA3M), RegWriteW && (RA2E == WA3W));
    end

    // Hazard detection; a register retiring this cycle is served by the write-first register file
    always_comb begin
        load_use   = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
        sb_raw_a   = sb[RA1D] && !(mul_done && (mul_done_wa == RA1D));
        sb_raw_b   = sb[RA2D] && !(mul_done && (mul_done_wa == RA2D));
        sb_raw     = sb_raw_a || sb_raw_b;
        struct_hz  = MulStartE && mul_busy && !mul_done;
        pc_pending = PCSrcD || PCSrcE || PCSrcM;
    end

    // Stall/flush arbitration: reset flushes everything, a taken branch beats any ID/EX stall
    always_comb begin
        stall_f = !reset && (load_use || sb_raw || struct_hz || pc_pending);
        stall_d = !reset && !BranchTakenE && (load_use || sb_raw || struct_hz);
        stall_e = !reset && !BranchTakenE && struct_hz;
        flush_d = reset || BranchTakenE || pc_pending || PCSrcW;
        flush_e = reset || BranchTakenE || load_use || sb_raw;
        issue_accept = MulStartE && !stall_e && !flush_e;
    end

    // Drive the module outputs from the arbitration results and tracker status
    always_comb begin
        StallF   = stall_f;
        StallD   = stall_d;
        StallE   = stall_e;
        FlushD   = flush_d;
        FlushE   = flush_e;
        MulBusy  = mul_busy;
        MulDoneW = mul_done;
        MulWAW   = mul_done_wa;
    end

`ifdef HAZARD_UNIT_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters for fetch stalls and any ID/EX flush
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if ((flush_d || flush_e) && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_unit_sb.md
HAZARD_UNIT_SB -- requirements
Module: hazard_unit_sb

Interface
REQ-001 Parameter NREG, default 16: architectural register count; register address width RW = clog2(NREG).
REQ-002 Parameter MUL_LAT, default 3: multi-cycle unit latency in cycles, legal range 2..15.
REQ-003 The port list SHALL be exactly as follows, with clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  reset; synchronous, active-high.
- RA1D, RA2D  in  RW  ID-stage source addresses.
- RA1E, RA2E  in  RW  EX-stage source addresses.
- WA3E, WA3M, WA3W  in  RW  EX/MEM/WB destination addresses.
- RegWriteM, RegWriteW  in  1  MEM/WB write enables.
- MemtoRegE  in  1  EX holds a load.
- MulStartE, MulWAE  in  1, RW  EX issues a multi-cycle op, and that op's destination.
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  per-stage PC-write flags.
- BranchTakenE  in  1  branch resolved taken in EX.
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = WB result, 10 = MEM result.
- StallF, StallD, StallE  out  1  hold the IF, ID and EX pipeline registers.
- FlushD, FlushE  out  1  clear the ID and EX pipeline registers.
- MulBusy  out  1  multi-cycle unit is occupied.
- MulDoneW, MulWAW  out  1, RW  multi-cycle result is written this cycle, and its destination.

Function
REQ-004 Forwarding SHALL be combinational: a MEM match with RegWriteM gives 10; otherwise a WB match with RegWriteW gives 01; otherwise 00. It is evaluated per operand.
REQ-005 Load-use: MemtoRegE with (RA1D==WA3E or RA2D==WA3E) SHALL assert StallF, StallD and FlushE for exactly one cycle.
REQ-006 The multi-cycle tracker SHALL hold a down-counter (4 bits) and a scoreboard (NREG bits).
REQ-007 An accepted issue is MulStartE=1 with StallE=0 and FlushE=0. It SHALL load the counter with MUL_LAT-1, set scoreboard[MulWAE] and latch MulWAE.
REQ-008 MulBusy SHALL equal (counter != 0).
REQ-009 The counter SHALL decrement each cycle while nonzero.
REQ-010 On the 1->0 counter transition, MulDoneW SHALL pulse for one cycle with MulWAW = latched address, and the scoreboard bit SHALL clear on the same edge.
REQ-011 Structural hazard: MulStartE while MulBusy and not in the MulDoneW cycle SHALL assert StallF, StallD and StallE until that cycle. The issue SHALL then be accepted on that cycle (back-to-back issue with no bubble).
REQ-012 Scoreboard RAW: if ID reads a register whose scoreboard bit is set and MulDoneW is not asserted for that address, StallF, StallD and FlushE SHALL assert. In the MulDoneW cycle the register file write-first path serves the read, and no stall is raised.
REQ-013 Simultaneous clear and set of the same scoreboard bit: set wins.
REQ-014 Control: if any of PCSrcD, PCSrcE or PCSrcM is high, StallF SHALL assert. PCSrcW or any pending PC write SHALL assert FlushD.
REQ-015 BranchTakenE SHALL assert FlushD and FlushE, and SHALL deassert StallD and StallE in that cycle (flush beats stall).
REQ-016 An in-flight multi-cycle op is older than the branch and SHALL complete normally.
REQ-017 A MulStartE flushed by BranchTakenE SHALL not be accepted.
REQ-018 All stall/flush outputs SHALL be combinational from inputs and registered state; there is zero added latency.

Reset
REQ-019 reset SHALL clear the counter, the scoreboard and the latched address on the next clock edge.
REQ-020 While reset is high, FlushD=FlushE=1, all stalls=0, MulBusy=0 and MulDoneW=0.
REQ-021 Reset mid-operation SHALL abandon the op with no MulDoneW pulse.

Configuration
REQ-022 With HAZARD_UNIT_PERF_EN defined, the block SHALL add outputs StallCnt[15:0] and FlushCnt[15:0].
- StallCnt counts cycles with StallF=1; FlushCnt counts cycles with FlushD or FlushE = 1.
- Both are saturating at 16'hFFFF and cleared by reset.
REQ-023 Without HAZARD_UNIT_PERF_EN, those ports and counters SHALL be absent.

Structure
REQ-024 Package hazard_pkg SHALL hold the FWD_RF/FWD_W/FWD_M encodings, the NREG default and the counter width.
REQ-025 Counter, scoreboard and latched address SHALL live in sub-module mul_tracker; hazard_unit_sb holds forwarding and stall/flush arbitration.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10; drop RegWriteM -> 01.
- MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for one cycle, then 0.
- MUL_LAT=3, issue to R7, then RA1D=7 next cycle -> MulBusy 2 cycles, StallD for 1 cycle, MulDoneW pulse with MulWAW=7, no stall in that cycle.
- Second MulStartE one cycle after first -> StallE=1 until MulDoneW, then accepted; no gap in MulBusy.
- BranchTakenE coincident with scoreboard stall -> FlushD=FlushE=1, StallD=0; busy op still reaches MulDoneW.
- reset pulsed with counter=1 -> no MulDoneW; MulBusy=0 and scoreboard empty next cycle; with HAZARD_UNIT_PERF_EN, counters read 0.
